// File: rtl/sram_ctrl.sv
// sram_ctrl: wait-state controller for the asynchronous 16-bit board SRAM.
// Define SRAM_CTRL_RDBUF_EN to add a one-entry read buffer.
module sram_ctrl #(
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 1
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        sel,
   input  logic [15:0] addr,
   input  logic [2:0]  bank,
   input  logic        r,
   input  logic [1:0]  w,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic [17:0] sram_addr,
   input  logic [15:0] sram_dq_i,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ce_n_q, ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        ub_n_q, ub_n_d;
   logic        lb_n_q, lb_n_d;
   logic        dq_oe_q, dq_oe_d;
   logic [15:0] dq_o_q, dq_o_d;
   logic [17:0] addr_q, addr_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;

   logic        req_wr;
   logic        req_rd;
   logic [17:0] req_tag;
   logic        buf_hit;
   logic        addr_unused;

   // Write wins when both r and w are presented.
   assign req_wr      = sel & (|w);
   assign req_rd      = sel & r & ~(|w);
   assign req_tag     = {bank, addr[15:1]};
   assign addr_unused = addr[0];

`ifdef SRAM_CTRL_RDBUF_EN
   logic        buf_vld_q, buf_vld_d;
   logic [17:0] buf_tag_q, buf_tag_d;
   logic [15:0] buf_dat_q, buf_dat_d;

   assign buf_hit = buf_vld_q & (buf_tag_q == req_tag);
`else
   assign buf_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      ub_n_d  = ub_n_q;
      lb_n_d  = lb_n_q;
      dq_oe_d = dq_oe_q;
      dq_o_d  = dq_o_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
      buf_vld_d = buf_vld_q;
      buf_tag_d = buf_tag_q;
      buf_dat_d = buf_dat_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_wr) begin
               addr_d  = req_tag;
               dq_o_d  = wdata;
               dq_oe_d = 1'b1;
               ce_n_d  = 1'b0;
               ub_n_d  = ~w[1];
               lb_n_d  = ~w[0];
               state_d = WR_SETUP;
`ifdef SRAM_CTRL_RDBUF_EN
               if (buf_hit) begin
                  if (w[1]) buf_dat_d[15:8] = wdata[15:8];
                  if (w[0]) buf_dat_d[7:0]  = wdata[7:0];
               end
`endif
            end else if (req_rd && buf_hit) begin
`ifdef SRAM_CTRL_RDBUF_EN
               rdata_d = buf_dat_q;
`endif
               state_d = DONE;
            end else if (req_rd) begin
               addr_d  = req_tag;
               ce_n_d  = 1'b0;
               oe_n_d  = 1'b0;
               ub_n_d  = 1'b0;
               lb_n_d  = 1'b0;
               cnt_d   = 4'(RD_WAIT);
               state_d = RD;
            end
         end
         RD: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = sram_dq_i;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               ub_n_d  = 1'b1;
               lb_n_d  = 1'b1;
               state_d = DONE;
`ifdef SRAM_CTRL_RDBUF_EN
               buf_vld_d = 1'b1;
               buf_tag_d = addr_q;
               buf_dat_d = sram_dq_i;
`endif
            end
         end
         WR_SETUP: begin
            we_n_d  = 1'b0;
            cnt_d   = 4'(WR_WAIT);
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               we_n_d  = 1'b1;
               state_d = WR_HOLD;
            end
         end
         WR_HOLD: begin
            ce_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
         dq_o_q  <= 16'h0000;
         addr_q  <= 18'h00000;
         rdata_q <= 16'h0000;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
         dq_oe_q <= dq_oe_d;
         dq_o_q  <= dq_o_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

`ifdef SRAM_CTRL_RDBUF_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         buf_vld_q <= 1'b0;
         buf_tag_q <= 18'h00000;
         buf_dat_q <= 16'h0000;
      end else begin
         buf_vld_q <= buf_vld_d;
         buf_tag_q <= buf_tag_d;
         buf_dat_q <= buf_dat_d;
      end
   end
`endif

   assign rdata      = rdata_q;
   assign ack        = ack_q;
   assign busy       = (state_q != IDLE);
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_ub_n  = ub_n_q;
   assign sram_lb_n  = lb_n_q;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Wait-state controller between the b16 CPU/debugger memory bus and the board's asynchronous 16-bit SRAM.
- Sits downstream of the address decoder. It consumes the bus request when the SRAM region is selected and returns a registered `ack` that the top level uses to gate CPU `run`.
- Generates glitch-free registered SRAM strobes with programmable setup/pulse/hold timing. This replaces the free-running READY-counter wait scheme.

Parameters:
- RD_WAIT, 1, extra clk cycles SRAM is held in read (OE low) before data capture; range 0..15.
- WR_WAIT, 1, extra clk cycles WE_N is held low beyond the first; range 0..15.

Ports:
- clk  input  1  system clock (50 MHz)
- nreset  input  1  asynchronous active-low reset
- sel  input  1  SRAM region selected by the address decoder
- addr  input  16  CPU byte address; bit 0 ignored
- bank  input  3  upper SRAM address bits
- r  input  1  read request
- w  input  2  byte write enables, [1]=high byte, [0]=low byte
- wdata  input  16  write data
- rdata  output  16  read data, valid while ack=1
- ack  output  1  transaction complete, one-cycle pulse
- busy  output  1  state != IDLE
- sram_addr  output  18  {bank, addr[15:1]}
- sram_dq_i  input  16  SRAM data bus in
- sram_dq_o  output  16  SRAM data bus out
- sram_dq_oe  output  1  top level drives SRAM_DQ from sram_dq_o when 1
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  SRAM strobes, all registered

Behaviour:
- Reset is nreset, asynchronous, active-low; clock is clk.
  - Outputs in reset: all *_n = 1, sram_dq_oe=0, ack=0, busy=0, rdata=0, sram_addr=0, sram_dq_o=0, state=IDLE, wait counter=0.
- A request is `sel & (r | |w)`, sampled only in IDLE.
  - If r and |w are both set, the write wins and r is ignored.
  - On acceptance, addr, bank, w and wdata are latched. Later bus changes do not affect the transaction in flight.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. The wait counter is 4 bits.
- IDLE, request is a read:
  - Set ce_n=0, oe_n=0, ub_n=0, lb_n=0, sram_addr; cnt<=RD_WAIT; go to RD.
- RD:
  - cnt!=0: decrement.
  - cnt==0: rdata<=sram_dq_i, deassert ce_n/oe_n/ub_n/lb_n, go to DONE.
  - Latency: request sampled at edge N gives ack high during the cycle after edge N+RD_WAIT+2.
- IDLE, request is a write:
  - Set ce_n=0, sram_dq_oe=1, sram_dq_o=wdata, ub_n=~w[1], lb_n=~w[0]; we_n stays 1; go to WR_SETUP.
- WR_SETUP:
  - we_n<=0, cnt<=WR_WAIT, go to WR_PULSE.
- WR_PULSE:
  - cnt!=0: decrement.
  - cnt==0: we_n<=1, go to WR_HOLD.
  - we_n is low for exactly WR_WAIT+1 cycles.
- WR_HOLD:
  - Address and data stay driven for one cycle with we_n=1.
  - Then ce_n=1, ub_n=1, lb_n=1, sram_dq_oe=0; go to DONE.
- DONE:
  - ack=1 for exactly one cycle; go to IDLE unconditionally.
  - A request present in the following IDLE cycle is a new transaction. This turnaround prevents the completed request from re-triggering.
- Cycle counts:
  - A write from acceptance to ack is WR_WAIT+4 cycles.
  - A read from acceptance to ack is RD_WAIT+2 cycles.
- sram_dq_oe and oe_n are never both active.
  - oe_n only goes low in reads; dq_oe only goes high in writes.
  - In both cases the transaction starts from IDLE, where both are inactive.
- sel low, or no r/w, in IDLE: nothing happens and all strobes stay inactive.
- Reset mid-transaction: immediate abort and all strobes go inactive asynchronously. No ack is produced and the write may be partial.
- rdata holds its last value until the next read capture. Writes do not alter rdata.

Optional Feature:
- SRAM_CTRL_RDBUF_EN adds a one-entry read buffer: a valid bit, an 18-bit tag and 16 bits of data.
  - Read hit in IDLE (valid and tag=={bank,addr[15:1]}): rdata<=buffer data, go straight to DONE with no SRAM strobes. ack comes 1 cycle after acceptance.
  - Read miss: normal RD. On capture, fill the buffer and set valid.
  - Write whose tag matches: merge the enabled bytes into the buffer at acceptance.
  - Reset clears valid.
- Without the macro, every read performs an SRAM access and there is no buffer logic.

Test Plan:
- Read, RD_WAIT=1, bank=0, addr=0x1234, r=1, sram_dq_i=0xBEEF.
  - Response: sram_addr=0x0091A, oe_n/ce_n low for 2 cycles, ack pulse 3 cycles after acceptance edge, rdata=0xBEEF.
- Write, WR_WAIT=1, addr=0x0010, w=2'b10, wdata=0xA55A.
  - Response: ub_n=0, lb_n=1, dq_oe=1, we_n low exactly 2 cycles, dq stable 1 cycle before and after the we_n pulse, ack at cycle 5.
- r=1 and w=2'b11 together.
  - Response: write sequence executed, oe_n never low.
- sel=0 with r=1 for 10 cycles.
  - Response: no strobes, ack=0, busy=0.
- nreset low during WR_PULSE.
  - Response: we_n/ce_n go to 1 and dq_oe to 0 without waiting for clk; no ack; IDLE after release.
- With SRAM_CTRL_RDBUF_EN, read 0x0040, then write w=2'b01 0x00CC to 0x0040, then read 0x0040 again.
  - Response: second read returns merged data with ack 1 cycle after acceptance and no oe_n pulse.
